// File: rtl/route_stage_pkg.sv
// Shared types for the routing stage: packet, routing-table entry and the
// reset-time table default. Optional per-port stats use macro ROUTE_STATS_EN.
package RouterPkg;

    localparam int TBL_SIZE = 16;

    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  src;
        logic [15:0] data;
    } pkt_t;

    typedef struct packed {
        logic       en;
        logic [2:0] port;
    } route_entry_t;

    // Local node goes to port 0, the next two nodes to ports 2/3, everything else to port 1.
    function automatic route_entry_t tbl_default(input logic [3:0] rid, input logic [3:0] addr);
        route_entry_t e;
        logic [3:0]   rid1;
        logic [3:0]   rid2;
        rid1   = rid + 4'd1;
        rid2   = rid + 4'd2;
        e.en   = 1'b1;
        if (addr == rid)       e.port = 3'd0;
        else if (addr == rid1) e.port = 3'd2;
        else if (addr == rid2) e.port = 3'd3;
        else                   e.port = 3'd1;
        return e;
    endfunction

endpackage

// File: rtl/route_stage_fifo.sv
// Per-output-port FIFO; head is shown combinationally and forced to zero when empty.
// Push while full is honoured only together with a pop in the same cycle.
module route_fifo
    import RouterPkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = pkt_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/route_stage.sv
// Table-driven single-input router feeding one FIFO per output port.
// Define ROUTE_STATS_EN to add saturating per-port delivered counters (port_cnt).
module route_stage
    import RouterPkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ROUTER_ID  = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  pkt_t                         in_pkt,
    input  logic                         in_valid,
    output logic                         in_ready,
    output pkt_t [NUM_PORTS-1:0]         out_pkt,
    output logic [NUM_PORTS-1:0]         out_valid,
    input  logic [NUM_PORTS-1:0]         out_ready,
    input  logic                         tbl_we,
    input  logic [3:0]                   tbl_addr,
    input  route_entry_t                 tbl_entry,
    output logic [15:0]                  drop_cnt
`ifdef ROUTE_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][15:0]   port_cnt
`endif
);

    route_entry_t               tbl_q [TBL_SIZE];
    route_entry_t               route;
    logic                       drop;
    logic [NUM_PORTS-1:0]       sel, push, pop, full, empty;
    logic [15:0]                drop_cnt_q, drop_cnt_d;

    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;

    // A full FIFO still accepts when its head leaves in the same cycle.
    always_comb begin
        route = tbl_q[in_pkt.dest];
        drop  = !route.en || (int'(route.port) >= NUM_PORTS);
        sel   = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            sel[i] = !drop && (route.port == 3'(i));
        in_ready = !reset && (drop || ((sel & full & ~pop) == '0));
        push     = (in_valid && in_ready) ? sel : '0;
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && in_ready && drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Lookup reads the registered table, so a same-cycle write only affects later packets.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < TBL_SIZE; a++)
                tbl_q[a] <= tbl_default(4'(ROUTER_ID), 4'(a));
            drop_cnt_q <= '0;
        end else begin
            if (tbl_we) tbl_q[tbl_addr] <= tbl_entry;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        route_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (pkt_t)
        ) u_fifo (
            .clk_i   (clock),
            .rst_i   (reset),
            .push_i  (push[g]),
            .data_i  (in_pkt),
            .pop_i   (out_ready[g]),
            .data_o  (out_pkt[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );
    end

`ifdef ROUTE_STATS_EN
    logic [NUM_PORTS-1:0][15:0] port_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            port_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++)
                if (pop[i] && port_cnt_q[i] != 16'hFFFF)
                    port_cnt_q[i] <= port_cnt_q[i] + 16'd1;
        end
    end

    assign port_cnt = port_cnt_q;
`endif

endmodule

// File: tb/tb_route_stage.sv
// Directed scenarios plus randomized traffic for route_stage, checked against
// a queue-based reference model (per-port queues, table array, drop counter).
module tb_route_stage;
    import RouterPkg::*;

    localparam int NP    = 4;
    localparam int DEPTH = 2;
    localparam int RID   = 0;

    logic                clock = 1'b0;
    logic                reset;
    pkt_t                in_pkt;
    logic                in_valid;
    logic                in_ready;
    pkt_t [NP-1:0]       out_pkt;
    logic [NP-1:0]       out_valid;
    logic [NP-1:0]       out_ready;
    logic                tbl_we;
    logic [3:0]          tbl_addr;
    route_entry_t        tbl_entry;
    logic [15:0]         drop_cnt;
`ifdef ROUTE_STATS_EN
    logic [NP-1:0][15:0] port_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pkt_t         mq [NP][$];
    route_entry_t mtbl [16];
    int           mdrops;
    int           mpops [NP];
    int           obs_pops [NP];
    pkt_t         obs2 [$];

    route_stage #(.NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .ROUTER_ID(RID)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pkt   (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_entry (tbl_entry),
        .drop_cnt  (drop_cnt)
`ifdef ROUTE_STATS_EN
        ,
        .port_cnt  (port_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t mk(input int dest);
        pkt_t p;
        p.dest = 4'(dest);
        p.src  = 4'($urandom_range(0, 15));
        p.data = 16'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 16; a++) mtbl[a] = '{en: 1'b1, port: 3'd1};
        mtbl[RID % 16].port       = 3'd0;
        mtbl[(RID + 1) % 16].port = 3'd2;
        mtbl[(RID + 2) % 16].port = 3'd3;
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            mpops[i] = 0;
        end
        mdrops = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_pkt   = mk(0);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pkt", out_pkt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clock); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        tbl_we   = 1'b0;
        model_reset();
    endtask

    // Compare outputs against the model for the inputs already applied, then advance one clock.
    task automatic step();
        route_entry_t e;
        logic         drop;
        logic         rdy;
        int           p;
        pkt_t         hexp;
        #2;
        e    = mtbl[in_pkt.dest];
        drop = !e.en || (int'(e.port) >= NP);
        p    = int'(e.port);
        if (drop) rdy = 1'b1;
        else      rdy = (mq[p].size() < DEPTH) || out_ready[p];
        chk("in_ready", in_ready, rdy);
        chk("drop_cnt", drop_cnt, mdrops);
        for (int i = 0; i < NP; i++) begin
            hexp = '0;
            if (mq[i].size() > 0) hexp = mq[i][0];
            chk($sformatf("out_valid%0d", i), out_valid[i], mq[i].size() > 0);
            chk($sformatf("out_pkt%0d", i), out_pkt[i], hexp);
`ifdef ROUTE_STATS_EN
            chk($sformatf("port_cnt%0d", i), port_cnt[i], mpops[i]);
`endif
            if (out_valid[i] && out_ready[i]) begin
                obs_pops[i]++;
                if (i == 2) obs2.push_back(out_pkt[i]);
            end
        end
        for (int i = 0; i < NP; i++)
            if (mq[i].size() > 0 && out_ready[i]) begin
                void'(mq[i].pop_front());
                if (mpops[i] < 65535) mpops[i]++;
            end
        if (in_valid && rdy) begin
            if (drop) begin
                if (mdrops < 65535) mdrops++;
            end else begin
                mq[p].push_back(in_pkt);
            end
        end
        if (tbl_we) mtbl[tbl_addr] = tbl_entry;
        @(posedge clock); #1;
    endtask

    initial begin
        pkt_t p0, p1, p2, p3;
        in_pkt    = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_entry = '0;
        for (int i = 0; i < NP; i++) obs_pops[i] = 0;
        do_reset();
        step();

        // Local destination lands on port 0 one cycle later.
        p0 = mk(0); in_pkt = p0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;
        chk("lat1_valid0", out_valid[0], 1);
        chk("lat1_pkt0", out_pkt[0], p0);
        step();
        out_ready = '1;
        step();
        step();

        // Back-pressure on port 2, then in-order delivery.
        out_ready = '0;
        obs2.delete();
        p1 = mk(1); in_pkt = p1; in_valid = 1'b1; step();
        p2 = mk(1); in_pkt = p2; step();
        p3 = mk(1); in_pkt = p3;
        #2;
        chk("third_blocked", in_ready, 0);
        step();
        out_ready[2] = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("order_count", obs2.size(), 3);
        if (obs2.size() == 3) begin
            chk("order_1", obs2[0], p1);
            chk("order_2", obs2[1], p2);
            chk("order_3", obs2[2], p3);
        end

        // Simultaneous push and pop on a full port-3 FIFO.
        out_ready = '0;
        for (int i = 0; i < NP; i++) obs_pops[i] = 0;
        in_pkt = mk(2); in_valid = 1'b1; step();
        in_pkt = mk(2); step();
        in_pkt = mk(2); out_ready[3] = 1'b1;
        #2;
        chk("full_pushpop_rdy", in_ready, 1);
        step();
        in_valid = 1'b0; out_ready = '0;
        step();
        out_ready = '1;
        for (int k = 0; k < 4; k++) step();
        chk("full_pushpop_total", obs_pops[3], 3);

        // Same-cycle table write uses the old entry; the next packet sees the new one.
        out_ready = '0;
        in_pkt = mk(5); in_valid = 1'b1;
        tbl_we = 1'b1; tbl_addr = 4'd5; tbl_entry = '{en: 1'b0, port: 3'd1};
        step();
        tbl_we = 1'b0;
        in_pkt = mk(5);
        step();
        in_valid = 1'b0;
        #2;
        chk("tbl_old_entry_port1", out_valid[1], 1);
        chk("drop_cnt_one", drop_cnt, 1);
        step();

        // Reset with traffic queued restores empty FIFOs and default table.
        in_pkt = mk(0); in_valid = 1'b1; step();
        in_pkt = mk(2); step();
        do_reset();
        in_pkt = mk(5); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2;
        chk("default_tbl_port1", out_valid[1], 1);
        step();

`ifdef ROUTE_STATS_EN
        do_reset();
        out_ready = '1;
        in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_pkt = mk(3);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("stats_port1_five", port_cnt[1], 5);
`endif

        // Randomized traffic with occasional table rewrites and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            in_valid  = ($urandom_range(0, 9) < 7);
            in_pkt    = mk($urandom_range(0, 15));
            out_ready = NP'($urandom);
            tbl_we    = ($urandom_range(0, 19) == 0);
            tbl_addr  = 4'($urandom_range(0, 15));
            tbl_entry = '{en: ($urandom_range(0, 3) != 0), port: 3'($urandom_range(0, 7))};
            step();
        end
        in_valid  = 1'b0;
        tbl_we    = 1'b0;
        out_ready = '1;
        for (int k = 0; k < 4; k++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/route_stage.md
ROUTE_STAGE -- requirements
Module: route_stage

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of output ports (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: entries per output FIFO (power of 2, >=2).
REQ-003 SHALL have parameter ROUTER_ID, default 0: this router's node id (0..15).
REQ-004 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_pkt  in  pkt_t  input packet; pkt.dest is the 4-bit destination node.
REQ-007 SHALL have port in_valid  in  1  in_pkt is valid.
REQ-008 SHALL have port in_ready  out  1  stage accepts in_pkt this cycle.
REQ-009 SHALL have port out_pkt  out  pkt_t[NUM_PORTS]  head packet of each output FIFO.
REQ-010 SHALL have port out_valid  out  NUM_PORTS  per-port head valid.
REQ-011 SHALL have port out_ready  in  NUM_PORTS  per-port downstream accept.
REQ-012 SHALL have port tbl_we  in  1  routing-table write strobe.
REQ-013 SHALL have port tbl_addr  in  4  table entry (destination node) to write.
REQ-014 SHALL have port tbl_entry  in  route_entry_t  {en, port}, written on tbl_we.
REQ-015 SHALL have port drop_cnt  out  16  packets dropped (no valid route).

Function
REQ-016 SHALL look up in_pkt.dest in a 16-entry registered routing table; entry en=1 selects output port, en=0 or port>=NUM_PORTS means drop.
REQ-017 SHALL assert in_ready when the route is a drop, or the selected FIFO is not full, or it is full and popped this cycle; in_ready depends on in_pkt.dest combinationally.
REQ-018 SHALL transfer on in_valid&&in_ready; a routed packet appears at out_pkt/out_valid of its port the next cycle (latency 1) when that FIFO was empty.
REQ-019 SHALL pop a FIFO on out_valid[i]&&out_ready[i]; out_pkt[i] SHALL be held stable while out_valid[i]&&!out_ready[i].
REQ-020 SHALL support simultaneous push and pop on one FIFO, including when full; occupancy unchanged.
REQ-021 SHALL wrap FIFO pointers modulo FIFO_DEPTH; preserve per-port packet order.
REQ-022 SHALL increment drop_cnt on each accepted dropped packet, saturating at 16'hFFFF.
REQ-023 SHALL route a packet accepted in the same cycle as tbl_we to the same address using the old entry; the new entry applies from the next cycle.
REQ-024 SHALL leave out_pkt[i] at '0 when FIFO i is empty.

Reset
REQ-025 SHALL on reset clear all FIFOs (out_valid='0, out_pkt='0), clear drop_cnt, and load table defaults: ROUTER_ID->port 0; (ROUTER_ID+1)%16->port 2; (ROUTER_ID+2)%16->port 3; all others->port 1; all en=1 (ports >=NUM_PORTS yield drop).
REQ-026 SHALL discard in-flight packets when reset asserts mid-operation; in_ready SHALL be 0 while reset is high.

Configuration
REQ-027 SHALL, with ROUTE_STATS_EN defined, add output port_cnt  out  16[NUM_PORTS]: per-port delivered (popped) packet count, saturating, reset to 0.
REQ-028 SHALL, without ROUTE_STATS_EN, omit port_cnt and its logic; all other behaviour identical.

Structure
REQ-029 SHALL take pkt_t, route_entry_t (en bit + 3-bit port), and the table default function from package RouterPkg.
REQ-030 SHALL instantiate one sub-module route_fifo (parametrised pkt_t FIFO, depth FIFO_DEPTH, full/empty flags) per output port.

Verification
REQ-031 SHALL cover: reset, ROUTER_ID=0, push dest=0 -> out_valid[0]=1 next cycle, out_pkt[0]=input packet.
REQ-032 SHALL cover: out_ready[2]=0, push 3 pkts dest=1 (FIFO_DEPTH=2) -> third sees in_ready=0; raise out_ready[2] -> order 1,2,3 delivered.
REQ-033 SHALL cover: tbl_we addr=5 entry{en=0} same cycle as pkt dest=5 -> routed to port 1; next pkt dest=5 -> dropped, drop_cnt=1.
REQ-034 SHALL cover: full FIFO 3, simultaneous push and pop -> in_ready=1, occupancy stays 2, no loss.
REQ-035 SHALL cover: reset asserted with 2 packets queued -> out_valid='0, drop_cnt=0, table back to defaults.
REQ-036 SHALL cover: ROUTE_STATS_EN defined, 5 pops on port 1 -> port_cnt[1]=5.
